wb_commit_unit: RTL and testbench

Parametrised writeback/commit stage that replaces the fixed stall-driven writeback register.
- Accepts retiring instructions from MEM over a valid/ready handshake and drives the regfile and CSR write ports.
- Buffers each committed instruction in a trace FIFO so the difftest side can consume it at its own rate.
- Implements an ebreak halt state machine that drains the trace before asserting halt, plus a retire counter.

---
 rtl/wb_commit_unit.sv | 142 ++++++++++++++
 tb/tb_wb_commit_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback/commit stage driving regfile/CSR ports, buffering a commit trace and halting on ebreak.
module wb_commit_unit #(
  parameter int XLEN        = 64,
  parameter int CSR_AW      = 12,
  parameter int TRACE_DEPTH = 4,
  parameter int CNT_W       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_npc,
  input  logic [31:0]       in_inst,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic [XLEN-1:0]   in_rf_wdata,
  input  logic              in_csr_we,
  input  logic [CSR_AW-1:0] in_csr_waddr,
  input  logic [XLEN-1:0]   in_csr_wdata,
  input  logic              in_ebreak,
  input  logic              in_ecall,
  input  logic [XLEN-1:0]   a0_value,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              ecall_pulse,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [XLEN-1:0]   tr_pc,
  output logic [XLEN-1:0]   tr_npc,
  output logic [31:0]       tr_inst,
  output logic              tr_we,
  output logic [4:0]        tr_waddr,
  output logic [XLEN-1:0]   tr_wdata,
  output logic              halted,
  output logic [XLEN-1:0]   halt_code,
  output logic [CNT_W-1:0]  retire_cnt
);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2;
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   npc;
    logic [31:0]       inst;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              ebreak;
    logic              ecall;
  } wb_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [31:0]     inst;
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
  } tr_t;
  logic [1:0]       state_q, state_d;
  logic             wb_valid_q, wb_valid_d;
  wb_t              wb_q, wb_d;
  tr_t              mem_q [TRACE_DEPTH];
  tr_t              head;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [XLEN-1:0]  halt_code_q, halt_code_d;
  logic             ecall_q, ecall_d;
  logic             push, pop, accept, hit_ebreak, rf_we_m;
  always_comb begin
    push         = wb_valid_q;
    rf_we_m      = wb_valid_q & wb_q.rf_we & (wb_q.rf_waddr != 5'd0);
    tr_valid     = count_q != '0;
    pop          = tr_valid & tr_ready;
    in_ready     = (state_q == S_RUN) && ((count_q + CW'(wb_valid_q)) < CW'(TRACE_DEPTH));
    accept       = in_valid & in_ready;
    hit_ebreak   = (state_q == S_RUN) & wb_valid_q & wb_q.ebreak;
    wb_valid_d   = accept;
    wb_d         = accept ? {in_pc, in_npc, in_inst, in_rf_we, in_rf_waddr, in_rf_wdata,
                             in_csr_we, in_csr_waddr, in_csr_wdata, in_ebreak, in_ecall} : wb_q;
    rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    retire_cnt_d = retire_cnt_q + CNT_W'(push);
    ecall_d      = wb_valid_q & wb_q.ecall;
    halt_code_d  = hit_ebreak ? a0_value : halt_code_q;
    state_d      = hit_ebreak ? S_DRAIN :
                   (state_q == S_DRAIN && count_q == '0 && !push) ? S_HALT : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      wb_valid_q   <= 1'b0;
      wb_q         <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      retire_cnt_q <= '0;
      halt_code_q  <= '0;
      ecall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_valid_q   <= wb_valid_d;
      wb_q         <= wb_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      retire_cnt_q <= retire_cnt_d;
      halt_code_q  <= halt_code_d;
      ecall_q      <= ecall_d;
    end
  end
  // Trace storage needs no reset: the head is gated by tr_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wb_q.pc, wb_q.npc, wb_q.inst, rf_we_m, wb_q.rf_waddr, wb_q.rf_wdata};
  end
  assign head        = tr_valid ? mem_q[rd_ptr_q] : '0;
  assign rf_we       = rf_we_m;
  assign rf_waddr    = wb_valid_q ? wb_q.rf_waddr : '0;
  assign rf_wdata    = wb_valid_q ? wb_q.rf_wdata : '0;
  assign csr_we      = wb_valid_q & wb_q.csr_we;
  assign csr_waddr   = wb_valid_q ? wb_q.csr_waddr : '0;
  assign csr_wdata   = wb_valid_q ? wb_q.csr_wdata : '0;
  assign ecall_pulse = ecall_q;
  assign tr_pc       = head.pc;
  assign tr_npc      = head.npc;
  assign tr_inst     = head.inst;
  assign tr_we       = head.we;
  assign tr_waddr    = head.waddr;
  assign tr_wdata    = head.wdata;
  assign halted      = state_q == S_HALT;
  assign halt_code   = halt_code_q;
  assign retire_cnt  = retire_cnt_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: randomized bench for wb_commit_unit against a queue-based commit model.
module tb_wb_commit_unit;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [63:0] in_pc = '0, in_npc = '0, in_rf_wdata = '0, in_csr_wdata = '0, a0_value = '0;
  logic [31:0] in_inst = '0;
  logic in_rf_we = 1'b0, in_csr_we = 1'b0, in_ebreak = 1'b0, in_ecall = 1'b0, tr_ready = 1'b0;
  logic [4:0] in_rf_waddr = '0;
  logic [11:0] in_csr_waddr = '0;
  logic rf_we, csr_we, ecall_pulse, tr_valid, tr_we, halted;
  logic [4:0] rf_waddr, tr_waddr;
  logic [11:0] csr_waddr;
  logic [63:0] rf_wdata, csr_wdata, tr_pc, tr_npc, tr_wdata, halt_code, retire_cnt;
  logic [31:0] tr_inst;
  wb_commit_unit #(.XLEN(64), .CSR_AW(12), .TRACE_DEPTH(D), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_npc(in_npc),
    .in_inst(in_inst), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
    .in_csr_we(in_csr_we), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
    .in_ebreak(in_ebreak), .in_ecall(in_ecall), .a0_value(a0_value), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .ecall_pulse(ecall_pulse), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_npc(tr_npc),
    .tr_inst(tr_inst), .tr_we(tr_we), .tr_waddr(tr_waddr), .tr_wdata(tr_wdata), .halted(halted),
    .halt_code(halt_code), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [63:0] pc, npc, wd, cd;
    logic [31:0] inst;
    logic we, cwe, eb, ec;
    logic [4:0] wa;
    logic [11:0] ca;
  } ins_t;
  typedef struct {
    logic [63:0] pc, npc, wd;
    logic [31:0] inst;
    logic we;
    logic [4:0] wa;
  } te_t;
  ins_t stg;
  bit stg_v;
  te_t q[$];
  int m_state;
  logic [63:0] m_cnt, m_hc;
  bit m_ec;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask
  function automatic ins_t cur_in();
    ins_t r;
    r.pc = in_pc; r.npc = in_npc; r.inst = in_inst; r.we = in_rf_we; r.wa = in_rf_waddr;
    r.wd = in_rf_wdata; r.cwe = in_csr_we; r.ca = in_csr_waddr; r.cd = in_csr_wdata;
    r.eb = in_ebreak; r.ec = in_ecall;
    return r;
  endfunction
  // Advances the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit push, pop, rdy;
    int sz;
    if (rst) begin
      stg_v = 0; q.delete(); m_state = 0; m_cnt = 0; m_hc = 0; m_ec = 0;
      return;
    end
    sz = q.size();
    rdy = m_state == 0 && sz + int'(stg_v) < D;
    push = stg_v;
    pop = sz != 0 && tr_ready;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back('{pc: stg.pc, npc: stg.npc, wd: stg.wd, inst: stg.inst,
                    we: stg.we && stg.wa != 0, wa: stg.wa});
      m_cnt++;
    end
    m_ec = push && stg.ec;
    if (m_state == 0 && push && stg.eb) begin
      m_state = 1; m_hc = a0_value;
    end else if (m_state == 1 && sz == 0 && !push) m_state = 2;
    stg_v = in_valid && rdy;
    if (stg_v) stg = cur_in();
  endtask
  task automatic check_all();
    te_t h;
    bit hv;
    hv = q.size() != 0;
    if (hv) h = q[0];
    check("in_ready", in_ready, m_state == 0 && q.size() + int'(stg_v) < D);
    check("rf_we", rf_we, stg_v && stg.we && stg.wa != 0);
    check("rf_waddr", rf_waddr, stg_v ? stg.wa : 0);
    check("rf_wdata", rf_wdata, stg_v ? stg.wd : 0);
    check("csr_we", csr_we, stg_v && stg.cwe);
    check("csr_waddr", csr_waddr, stg_v ? stg.ca : 0);
    check("csr_wdata", csr_wdata, stg_v ? stg.cd : 0);
    check("ecall_pulse", ecall_pulse, m_ec);
    check("tr_valid", tr_valid, hv);
    check("tr_pc", tr_pc, hv ? h.pc : 0);
    check("tr_npc", tr_npc, hv ? h.npc : 0);
    check("tr_inst", tr_inst, hv ? h.inst : 0);
    check("tr_we", tr_we, hv ? h.we : 0);
    check("tr_waddr", tr_waddr, hv ? h.wa : 0);
    check("tr_wdata", tr_wdata, hv ? h.wd : 0);
    check("halted", halted, m_state == 2);
    check("halt_code", halt_code, m_hc);
    check("retire_cnt", retire_cnt, m_cnt);
  endtask
  task automatic cyc();
    model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic set_in(input bit v, input logic [63:0] pc, input logic [4:0] rd, input bit we,
                        input logic [63:0] wd, input bit eb, input bit ec);
    in_valid = v; in_pc = pc; in_npc = pc + 64'd4; in_rf_waddr = rd; in_rf_we = we; in_rf_wdata = wd;
    in_ebreak = eb; in_ecall = ec; in_inst = $urandom;
    in_csr_we = $urandom_range(0, 1); in_csr_waddr = 12'($urandom);
    in_csr_wdata = {$urandom, $urandom}; a0_value = {$urandom, $urandom};
  endtask
  task automatic do_reset();
    rst = 1; in_valid = 0; cyc(); rst = 0;
  endtask
  initial begin
    @(negedge clk);
    cyc(); cyc(); rst = 0;
    set_in(1, 64'h8000_0000, 5, 1, 64'h1234, 0, 0); cyc();
    in_valid = 0; cyc(); cyc(); tr_ready = 1; cyc(); cyc();
    set_in(1, 64'h8000_0004, 0, 1, 64'hFFFF, 0, 1); cyc();
    in_valid = 0; cyc(); cyc(); cyc();
    tr_ready = 0;
    for (int i = 0; i < 8; i++) begin set_in(1, 64'(4 * i), 5'(i + 1), 1, 64'(i), 0, 0); cyc(); end
    tr_ready = 1; cyc(); tr_ready = 0;
    for (int i = 0; i < 3; i++) cyc();
    tr_ready = 1;
    for (int i = 0; i < 12; i++) begin set_in(1, 64'(16 + 4 * i), 5'(i), 1, 64'(i), 0, 0); cyc(); end
    in_valid = 0; for (int i = 0; i < 6; i++) cyc();
    tr_ready = 0;
    for (int i = 0; i < 2; i++) begin set_in(1, 64'(256 + 4 * i), 3, 1, 64'(i), 0, 0); cyc(); end
    set_in(1, 64'h200, 10, 1, 64'h77, 1, 0); a0_value = 0; cyc();
    in_valid = 0; cyc(); cyc();
    tr_ready = 1; for (int i = 0; i < 6; i++) cyc();
    for (int i = 0; i < 4; i++) begin set_in(1, 64'h300, 1, 1, 1, 0, 0); cyc(); end
    do_reset(); tr_ready = 0;
    for (int i = 0; i < 2; i++) begin set_in(1, 64'(512 + 4 * i), 4, 1, 64'(i), 0, 0); cyc(); end
    set_in(1, 64'h400, 10, 1, 64'h5, 1, 0); cyc();
    in_valid = 0; cyc(); cyc();
    do_reset(); cyc();
    for (int i = 0; i < 4000; i++) begin
      set_in($urandom_range(0, 3) != 0, {$urandom, $urandom}, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
             $urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0);
      tr_ready = $urandom_range(0, 2) != 0;
      if ((m_state == 2 && $urandom_range(0, 5) == 0) || $urandom_range(0, 400) == 0) rst = 1;
      cyc();
      rst = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
